// File: rtl/ps2_button_decoder_if.sv
// PS/2 line pair plus the decoded button/code outputs of ps2_button_decoder.
// master: keyboard/host side; slave: the decoder.
interface ps2_button_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] btn;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  btn,
        input  code,
        input  code_valid,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output btn,
        output code,
        output code_valid,
        output frame_err
    );
endinterface

// File: rtl/ps2_button_decoder.sv
// PS/2 keyboard receiver mapping make/break codes onto a held button vector.
// Optional macro PS2_PARITY_CHECK_EN rejects frames with bad odd parity.
module ps2_button_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 Reset,
    ps2_button_decoder_if.slave  bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    function automatic logic odd_parity(input logic [8:0] v);
        return ^v;
    endfunction

    // Bit 7 Pause .. bit 0 P2_Press; arrow keys only match with the E0 prefix.
    function automatic logic [7:0] key_mask(input logic [7:0] code_v, input logic ext_v);
        logic [7:0] m;
        m = 8'h00;
        if (ext_v) begin
            case (code_v)
                8'h6B:   m = 8'h08;
                8'h74:   m = 8'h04;
                8'h75:   m = 8'h01;
                default: m = 8'h00;
            endcase
        end else begin
            case (code_v)
                8'h4D:   m = 8'h80;
                8'h2D:   m = 8'h40;
                8'h1C:   m = 8'h20;
                8'h23:   m = 8'h10;
                8'h1D:   m = 8'h02;
                default: m = 8'h00;
            endcase
        end
        return m;
    endfunction

    logic [1:0]    clk_sync_r;
    logic [1:0]    data_sync_r;
    logic          filt_r;
    logic [FW-1:0] filt_cnt_r;
    logic          fall_s;
    logic          data_s;
    logic          frame_ok_s;
    logic [7:0]    mask_s;

    state_t        state_r;
    logic [3:0]    bit_cnt_r;
    logic [8:0]    shift_r;
    logic [TW-1:0] to_cnt_r;
    logic          ext_r;
    logic          brk_r;
    logic [7:0]    btn_r;
    logic [7:0]    code_r;
    logic          code_valid_r;
    logic          frame_err_r;

    // Two-flop synchronizers for the asynchronous PS/2 lines.
    always_ff @(posedge clk) begin
        if (Reset) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], bus.ps2_clk};
            data_sync_r <= {data_sync_r[0], bus.ps2_data};
        end
    end

    // Glitch filter: level follows the synced clock only after FILTER_LEN agreeing samples.
    always_ff @(posedge clk) begin
        if (Reset) begin
            filt_r     <= 1'b1;
            filt_cnt_r <= FW'(0);
        end else if (clk_sync_r[1] == filt_r) begin
            filt_cnt_r <= FW'(0);
        end else if (filt_cnt_r == FILT_LAST) begin
            filt_r     <= clk_sync_r[1];
            filt_cnt_r <= FW'(0);
        end else begin
            filt_cnt_r <= filt_cnt_r + FW'(1);
        end
    end

    // Falling-edge strobe fires in the cycle the filtered level drops; data is sampled then.
    always_comb begin
        fall_s = filt_r & ~clk_sync_r[1] & (filt_cnt_r == FILT_LAST);
        data_s = data_sync_r[1];
        mask_s = key_mask(shift_r[7:0], ext_r);
`ifdef PS2_PARITY_CHECK_EN
        frame_ok_s = data_s & odd_parity(shift_r);
`else
        frame_ok_s = data_s;
`endif
    end

    // Deframing FSM, timeout, prefix tracking and button state.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 4'd0;
            shift_r      <= 9'd0;
            to_cnt_r     <= TW'(0);
            ext_r        <= 1'b0;
            brk_r        <= 1'b0;
            btn_r        <= 8'h00;
            code_r       <= 8'h00;
            code_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            code_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            if (fall_s || (state_r == ST_IDLE)) begin
                to_cnt_r <= TW'(0);
            end else begin
                to_cnt_r <= to_cnt_r + TW'(1);
            end
            case (state_r)
                ST_IDLE: begin
                    if (fall_s && !data_s) begin
                        state_r   <= ST_RECV;
                        bit_cnt_r <= 4'd0;
                    end
                end
                ST_RECV: begin
                    if (fall_s) begin
                        // Nine bits shift in LSB first, leaving parity in bit 8.
                        shift_r   <= {data_s, shift_r[8:1]};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd8) begin
                            state_r <= ST_STOP;
                        end
                    end else if (to_cnt_r == TO_LAST) begin
                        state_r     <= ST_IDLE;
                        frame_err_r <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (fall_s) begin
                        state_r <= ST_IDLE;
                        if (frame_ok_s) begin
                            code_r       <= shift_r[7:0];
                            code_valid_r <= 1'b1;
                            if (shift_r[7:0] == 8'hE0) begin
                                ext_r <= 1'b1;
                            end else if (shift_r[7:0] == 8'hF0) begin
                                brk_r <= 1'b1;
                            end else begin
                                btn_r <= brk_r ? (btn_r & ~mask_s) : (btn_r | mask_s);
                                ext_r <= 1'b0;
                                brk_r <= 1'b0;
                            end
                        end else begin
                            frame_err_r <= 1'b1;
                        end
                    end else if (to_cnt_r == TO_LAST) begin
                        state_r     <= ST_IDLE;
                        frame_err_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.btn        = btn_r;
    assign bus.code       = code_r;
    assign bus.code_valid = code_valid_r;
    assign bus.frame_err  = frame_err_r;
endmodule
